// File: rtl/dp_req_scheduler.sv
`default_nettype none
// ============================================================================
// dp_req_scheduler
// Round-robin issue of NREQ operand triples to one shared fixed-latency
// datapath; the captured result is returned with the winning requester id.
// Revision: 1.0 - initial release
// ============================================================================
module dp_req_scheduler #(
  parameter int NREQ = 3,
  parameter int W    = 12,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  output logic [NREQ-1:0]   req_grant,
  output logic              dp_en,
  output logic [W-1:0]      dp_a,
  output logic [W-1:0]      dp_b,
  output logic [W-1:0]      dp_c,
  input  logic [W-1:0]      dp_f,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [1:0]        rsp_id,
  output logic              busy
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [W-1:0]  data_q, data_d;

  logic [3:0]    req_pad;
  logic [2:0]    cand;
  logic          win_found;
  logic [1:0]    win_idx;

  // Scan downward so the last hit, i.e. the one nearest ptr, wins.
  always_comb begin
    req_pad   = 4'(req_valid);
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (req_pad[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (!hold && win_found) begin
          state_d = S_ISSUE;
          a_d     = req_a[int'(win_idx)*W +: W];
          b_d     = req_b[int'(win_idx)*W +: W];
          c_d     = req_c[int'(win_idx)*W +: W];
          id_d    = win_idx;
          ptr_d   = (win_idx == 2'(NREQ - 1)) ? 2'd0 : win_idx + 2'd1;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          data_d  = dp_f;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      data_q  <= data_d;
    end
  end

  assign dp_en     = (state_q == S_ISSUE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign dp_c      = c_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_grant
    assign req_grant[i] = dp_en && (id_q == 2'(i));
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_req_scheduler.sv
`default_nettype none
// ============================================================================
// tb_dp_req_scheduler
// Directed self-checking bench with a LAT=2 adder stub as the datapath.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dp_req_scheduler;

  localparam int NREQ = 3;
  localparam int W    = 12;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              hold = 1'b0;
  logic              rsp_ready = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ*W-1:0] req_c = '0;
  logic [NREQ-1:0]   req_grant;
  logic              dp_en;
  logic [W-1:0]      dp_a, dp_b, dp_c, dp_f;
  logic              rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;
  logic [W-1:0]      p1 = '0;
  logic [W-1:0]      p2 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  dp_req_scheduler #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_grant(req_grant), .dp_en(dp_en),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_f(dp_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath stub: three-operand sum, two cycles of latency.
  always @(posedge clk) begin
    p1 <= dp_a + dp_b + dp_c;
    p2 <= p1;
  end
  assign dp_f = p2;

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
  endtask

  // Leaves the bench at a negedge with the DUT in IDLE (that cycle is cycle 0).
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0; req_valid = '0; hold = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 3'b111;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_grant, dp_en, dp_a, dp_b, dp_c, rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got grant=%b en=%b a=%h v=%b data=%h id=%0d busy=%b, want all 0",
               req_grant, dp_en, dp_a, rsp_valid, rsp_data, rsp_id, busy);
    end
    req_valid = '0;
    rst = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    set_ops(1, 12'h00F, 12'h010, 12'h100);
    req_valid = 3'b010;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (req_grant !== ((c == 1) ? 3'b010 : 3'b000) || dp_en !== (c == 1)) begin
        n_bad++;
        $display("FAIL single_issue c%0d: got grant=%b en=%b", c, req_grant, dp_en);
      end
      n_cmp++;
      if (rsp_valid !== (c == 4) || busy !== (c <= 4)) begin
        n_bad++;
        $display("FAIL single_status c%0d: got rsp_valid=%b busy=%b, want %b %b",
                 c, rsp_valid, busy, (c == 4), (c <= 4));
      end
      if (c == 4) begin
        n_cmp++;
        if (rsp_data !== 12'h11F || rsp_id !== 2'd1) begin
          n_bad++;
          $display("FAIL single_rsp: got data=%h id=%0d, want 11f id 1", rsp_data, rsp_id);
        end
      end
      if (c == 1) req_valid = '0;
    end
  endtask

  task automatic test_round_robin;
    int ng = 0;
    int nr = 0;
    logic [2:0] eg;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_ops(i, W'(i + 1), W'(16 * (i + 1)), W'(256 * (i + 1)));
    req_valid = 3'b111;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (req_grant != '0) begin
        eg = 3'b001 << (ng % 3);
        n_cmp++;
        if (req_grant !== eg || c != 1 + 5 * ng) begin
          n_bad++;
          $display("FAIL rr_grant #%0d: got %b at cycle %0d, want %b at cycle %0d",
                   ng, req_grant, c, eg, 1 + 5 * ng);
        end
        ng++;
      end
      if (rsp_valid === 1'b1) begin
        n_cmp++;
        if (rsp_id !== 2'(nr % 3) || rsp_data !== W'(12'h111 * (nr % 3 + 1))) begin
          n_bad++;
          $display("FAIL rr_rsp #%0d: got id=%0d data=%h, want id=%0d data=%h",
                   nr, rsp_id, rsp_data, nr % 3, W'(12'h111 * (nr % 3 + 1)));
        end
        nr++;
      end
    end
    req_valid = '0;
    n_cmp++;
    if (ng != 6 || nr != 6) begin
      n_bad++;
      $display("FAIL rr_count: got %0d grants %0d responses, want 6 and 6", ng, nr);
    end
  endtask

  task automatic test_stall;
    do_reset();
    set_ops(0, 12'h123, 12'h000, 12'h000);
    set_ops(1, 12'h001, 12'h002, 12'h003);
    req_valid = 3'b011;
    rsp_ready = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (req_grant !== 3'b001) begin
          n_bad++;
          $display("FAIL stall_first_grant: got %b, want 001", req_grant);
        end
        req_valid = 3'b010;
      end
      if (c >= 4 && c <= 9) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 12'h123 || rsp_id !== 2'd0 ||
            req_grant !== 3'b000 || dp_en !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_hold c%0d: got v=%b data=%h id=%0d grant=%b en=%b",
                   c, rsp_valid, rsp_data, rsp_id, req_grant, dp_en);
        end
        if (c == 9) rsp_ready = 1'b1;
      end
      if (c == 10) begin
        n_cmp++;
        if (busy !== 1'b0 || req_grant !== 3'b000) begin
          n_bad++;
          $display("FAIL stall_release: got busy=%b grant=%b, want 0 000", busy, req_grant);
        end
      end
      if (c == 11) begin
        n_cmp++;
        if (req_grant !== 3'b010) begin
          n_bad++;
          $display("FAIL stall_next_grant: got %b, want 010", req_grant);
        end
        req_valid = '0;
      end
      if (c == 14) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 12'h006) begin
          n_bad++;
          $display("FAIL stall_next_rsp: got v=%b id=%0d data=%h, want 1 1 006",
                   rsp_valid, rsp_id, rsp_data);
        end
      end
    end
  endtask

  task automatic test_hold;
    do_reset();
    hold = 1'b1;
    set_ops(2, 12'h00A, 12'h00B, 12'h00C);
    req_valid = 3'b100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (req_grant !== 3'b000 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_idle c%0d: got grant=%b busy=%b, want 000 0", c, req_grant, busy);
      end
    end
    hold = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (req_grant !== 3'b100) begin
          n_bad++;
          $display("FAIL hold_release_grant: got %b, want 100", req_grant);
        end
        req_valid = '0;
      end
      if (c == 4) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 12'h021) begin
          n_bad++;
          $display("FAIL hold_rsp: got v=%b id=%0d data=%h, want 1 2 021",
                   rsp_valid, rsp_id, rsp_data);
        end
      end
    end
  endtask

  task automatic test_hold_in_wait;
    do_reset();
    set_ops(0, 12'h001, 12'h001, 12'h001);
    req_valid = 3'b011;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (req_grant !== 3'b001) begin
          n_bad++;
          $display("FAIL holdw_grant: got %b, want 001", req_grant);
        end
      end
      if (c == 2) hold = 1'b1;
      if (c == 4) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 12'h003) begin
          n_bad++;
          $display("FAIL holdw_rsp: got v=%b id=%0d data=%h, want 1 0 003",
                   rsp_valid, rsp_id, rsp_data);
        end
      end
      if (c >= 5 && c <= 10) begin
        n_cmp++;
        if ({req_grant, busy} !== 4'b0000) begin
          n_bad++;
          $display("FAIL holdw_blocked c%0d: got grant=%b busy=%b", c, req_grant, busy);
        end
        if (c == 10) hold = 1'b0;
      end
      if (c == 11) begin
        n_cmp++;
        if (req_grant !== 3'b010) begin
          n_bad++;
          $display("FAIL holdw_resume: got %b, want 010", req_grant);
        end
        req_valid = '0;
      end
    end
  endtask

  task automatic test_reset_in_wait;
    do_reset();
    set_ops(0, 12'h100, 12'h020, 12'h003);
    req_valid = 3'b100;
    @(negedge clk);
    n_cmp++;
    if (req_grant !== 3'b100) begin
      n_bad++;
      $display("FAIL rstw_grant: got %b, want 100", req_grant);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 3'b011;
    @(negedge clk);
    n_cmp++;
    if ({req_grant, dp_en, dp_a, dp_b, dp_c, rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
      n_bad++;
      $display("FAIL rstw_outputs: got grant=%b en=%b a=%h v=%b data=%h id=%0d busy=%b, want all 0",
               req_grant, dp_en, dp_a, rsp_valid, rsp_data, rsp_id, busy);
    end
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (req_grant !== 3'b001) begin
          n_bad++;
          $display("FAIL rstw_ptr: got %b, want 001", req_grant);
        end
        req_valid = '0;
      end
      if (c == 4) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 12'h123) begin
          n_bad++;
          $display("FAIL rstw_rsp: got v=%b id=%0d data=%h, want 1 0 123",
                   rsp_valid, rsp_id, rsp_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_hold();
    test_hold_in_wait();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
